// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table front end.
//   ht_op_t        : command opcode (OP_INIT clears the table and must run alone)
//   ht_command_t   : command handed to the hash table
//   ht_result_t    : result returned by the hash table
//   ht_chan_idx_t  : channel index, wide enough for the largest supported channel count
//   ARB_RR / ARB_FIXED : accepted values of the ARB_MODE parameter
package hash_table_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef enum logic [1:0] {
        OP_INIT   = 2'd0,
        OP_INSERT = 2'd1,
        OP_LOOKUP = 2'd2,
        OP_DELETE = 2'd3
    } ht_op_t;

    typedef struct packed {
        ht_op_t      opcode;
        logic [15:0] key;
        logic [15:0] value;
    } ht_command_t;

    typedef struct packed {
        logic        hit;
        logic [15:0] value;
    } ht_result_t;

    typedef logic [$clog2(MAX_CHANNELS)-1:0] ht_chan_idx_t;

    localparam string ARB_RR    = "rr";
    localparam string ARB_FIXED = "fixed";

endpackage

// File: rtl/ht_tag_fifo.sv
// In-order tag FIFO: remembers which channel issued each outstanding command
// so results can be routed back in issue order.
//   clk_i, rst_i : clock, asynchronous active-high reset (pointers and count clear)
//   push, push_data : enqueue a channel index (ignored when full)
//   pop          : dequeue the head entry (ignored when empty)
//   full, empty  : status flags
//   count        : number of entries held
//   head         : channel index at the front of the queue
module ht_tag_fifo
    import hash_table_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  ht_chan_idx_t               push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output ht_chan_idx_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    ht_chan_idx_t  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ht_multi_port.sv
// Multi-port front end for a single hash table: arbitrates CHANNELS command
// sources onto one registered command port and routes in-order results back
// to the issuing channel using a tag FIFO.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_i/cmd_valid_i/cmd_ready_o       : per-channel command handshake
//   ht_cmd_o/ht_cmd_valid_o/ht_cmd_ready_i : registered command to hash table
//   ht_res_i/ht_res_valid_i/ht_res_ready_o : result from hash table
//   res_o/res_valid_o/res_ready_i       : per-channel result handshake
//   outstanding_o         : tags currently held
//   err_o                 : sticky, a result arrived with no tag held
// Handshakes: a transfer happens on a cycle where valid and ready are both 1;
// a producer holds its payload stable while valid=1 and ready=0.
module ht_multi_port
    import hash_table_pkg::*;
#(
    parameter int    CHANNELS        = 4,
    parameter int    MAX_OUTSTANDING = 16,
    parameter string ARB_MODE        = ARB_RR
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  ht_command_t                          cmd_i [CHANNELS],
    input  logic [CHANNELS-1:0]                  cmd_valid_i,
    output logic [CHANNELS-1:0]                  cmd_ready_o,
    output ht_command_t                          ht_cmd_o,
    output logic                                 ht_cmd_valid_o,
    input  logic                                 ht_cmd_ready_i,
    input  ht_result_t                           ht_res_i,
    input  logic                                 ht_res_valid_i,
    output logic                                 ht_res_ready_o,
    output ht_result_t                           res_o [CHANNELS],
    output logic [CHANNELS-1:0]                  res_valid_o,
    input  logic [CHANNELS-1:0]                  res_ready_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam bit FIXED_ARB = (ARB_MODE == ARB_FIXED);

    ht_chan_idx_t        rr_ptr;
    logic [CHANNELS-1:0] eligible;
    logic                can_accept;
    logic                lo_found;
    ht_chan_idx_t        lo_idx;
    logic                hi_found;
    ht_chan_idx_t        hi_idx;
    ht_chan_idx_t        grant_idx;
    logic                grant;
    ht_command_t         grant_cmd;

    logic                fifo_full;
    logic                fifo_empty;
    ht_chan_idx_t        fifo_head;
    logic                pop;

    // ---------------- arbiter ----------------
    // An OP_INIT may only issue into an empty pipeline; otherwise the channel
    // simply drops out of this cycle's arbitration.
    always_comb begin
        eligible = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            eligible[j] = cmd_valid_i[j] &&
                          !((cmd_i[j].opcode == OP_INIT) && !fifo_empty);
        end
    end

    assign can_accept = !rst_i && (!ht_cmd_valid_o || ht_cmd_ready_i) && !fifo_full;

    // Round-robin as two priority scans: first eligible at or above rr_ptr,
    // falling back to the lowest eligible index (which is also fixed mode).
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (!lo_found && eligible[j]) begin
                lo_found = 1'b1;
                lo_idx   = ht_chan_idx_t'(j);
            end
            if (!hi_found && eligible[j] && (ht_chan_idx_t'(j) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ht_chan_idx_t'(j);
            end
        end
    end

    assign grant_idx = (!FIXED_ARB && hi_found) ? hi_idx : lo_idx;
    assign grant     = can_accept && lo_found;

    always_comb begin
        cmd_ready_o = '0;
        grant_cmd   = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant_idx == ht_chan_idx_t'(j)) begin
                cmd_ready_o[j] = grant;
                grant_cmd      = cmd_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == ht_chan_idx_t'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------- command output register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ht_cmd_valid_o <= 1'b0;
            ht_cmd_o       <= '0;
        end else if (grant) begin
            ht_cmd_valid_o <= 1'b1;
            ht_cmd_o       <= grant_cmd;
        end else if (ht_cmd_ready_i) begin
            ht_cmd_valid_o <= 1'b0;
        end
    end

    // ---------------- tag FIFO ----------------
    ht_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (grant),
        .push_data(grant_idx),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding_o),
        .head     (fifo_head)
    );

    // ---------------- result routing ----------------
    // With no tag held the result has no owner: accept and drop it.
    always_comb begin
        res_valid_o    = '0;
        ht_res_ready_o = 1'b1;
        if (!fifo_empty) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (fifo_head == ht_chan_idx_t'(j)) begin
                    res_valid_o[j] = ht_res_valid_i;
                    ht_res_ready_o = res_ready_i[j];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < CHANNELS; j++) begin
            res_o[j] = ht_res_i;
        end
    end

    assign pop = ht_res_valid_i && ht_res_ready_o && !fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (ht_res_valid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

endmodule
